mandelbrot_iterator: RTL and testbench
======================================

# mandelbrot_iterator

Escape-time engine for the Mandelbrot accelerator. It accepts one pixel at a time from the coordinate mapper: the complex point c = a + jb plus the pixel's screen position. It iterates z ← z² + c in signed fixed point and emits the iteration count with the same position, which the frame RAM uses as its write data and write address {y,x}. It sits between the mapper and the RAM in the write path.

## Interface
Parameters:
- `ITER_W`, 8: width of the iteration count.
- `MAX_ITER`, 255: iteration cap, must be ≤ 2^ITER_W − 1.

Ports (clock and reset first):
- `clk`  in  1: single clock.
- `rst`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: mapper presents a pixel.
- `in_ready`  out  1: engine can accept a pixel.
- `a`  in  32: real part of c, signed Q4.28.
- `b`  in  32: imaginary part of c, signed Q4.28.
- `x_in`  in  10: pixel column.
- `y_in`  in  10: pixel row.
- `out_valid`  out  1: result available.
- `out_ready`  in  1: RAM side accepts the result.
- `count_out`  out  ITER_W: escape iteration count.
- `x_out`  out  10: captured pixel column.
- `y_out`  out  10: captured pixel row.

## Operation
- FSM states: IDLE, ITER, DONE.
- **IDLE:** `in_ready`=1. On `in_valid && in_ready`, capture a, b, x_in and y_in. Clear zr, zi and k to 0, then go to ITER.
- **ITER:** one iteration per cycle, evaluating z_k (z_0 = 0).
  - Compute the full-precision 64-bit products zr², zi² and zr·zi (Q8.56).
  - Escape test: zr² + zi² > 4.0 (4 << 56), evaluated in 65 bits with no truncation. Equality does not escape.
  - If escaped: `count_out` ← k, go to DONE.
  - Else if k == MAX_ITER: `count_out` ← MAX_ITER, go to DONE.
  - Else:
    - zr ← (zr² − zi²) >>> 28 + a
    - zi ← (2·zr·zi) >>> 28 + b
    - k ← k + 1
- **DONE:** `out_valid`=1. `count_out`, `x_out` and `y_out` stay stable until `out_ready`. On `out_valid && out_ready`, go to IDLE. `in_ready` is 0 in ITER and DONE, so there is no overlap between pixels.
- **Input range:** |a| and |b| must be ≤ 2.0. Under that range, every non-escaped z stays within ±6.5 and the Q4.28 state cannot overflow. Inputs outside the range give undefined counts.
- **Reset:** asserting `rst` at any time, including mid-ITER or in DONE with `out_ready` low, returns the FSM to IDLE. The in-flight pixel is dropped.

## Timing
- Reset values:
  - `in_ready`=1 (IDLE)
  - `out_valid`=0
  - `count_out`=0
  - `x_out`=0
  - `y_out`=0
  - internal zr, zi, k = 0
- Latency from the accept edge to `out_valid` high is count_out + 1 cycles. Example: count 3 gives 4 cycles.
- Pixel throughput: accept edge, then count_out + 1 cycles in ITER, then at least 1 DONE cycle. The next pixel can be accepted on the cycle after the output handshake.
- `out_valid` is registered. Outputs change only on the transition into DONE.

## Configuration
- `MANDEL_PERIOD_CHECK_EN`: compiles in periodicity detection.
- **With the macro:**
  - Hold a saved (zs_r, zs_i). It is loaded with the current z whenever k is a power of two (1, 2, 4, …).
  - If a non-escaped z_k exactly equals the saved value at k > 1 and k is not a load point, exit early to DONE with `count_out` = MAX_ITER.
- **Without the macro:** no saved registers. The engine always iterates to escape or to MAX_ITER.
- `count_out` is identical in both builds. Only latency differs.

## Structure
- `mandelbrot_pkg` holds:
  - `DATA_W`=32 and `FRAC_W`=28
  - the `ESCAPE_R2` constant (4.0 in Q8.56)
  - the FSM state enum typedef
  - the fixed-point typedef shared with the mapper
- Sub-module `fxp_mul`: combinational signed 32×32→64 multiply. It is instantiated three times (zr², zi², zr·zi).

## Test plan
- c = 0, `MAX_ITER`=255 → `count_out`=255 with x,y echoed. Without the macro, latency is 256 cycles. With the macro, latency is under 10 cycles.
- c = 1.0 + 0j → `count_out`=3 (z: 0, 1, 2, 5), `out_valid` 4 cycles after accept.
- c = 2.0 → `count_out`=2. c = −2.0 (|z|² stays exactly 4) → `count_out`=255, which checks that equality does not escape.
- `out_ready` held low for 20 cycles in DONE → outputs stable, `in_ready`=0, and a new `in_valid` is ignored until the handshake completes.
- `rst` pulled low mid-ITER of c = 0 → `out_valid`=0 and `in_ready`=1 immediately. The next pixel, c = 1.0, then gives count 3.
- Back-to-back stream of 16 pixels with random |a|,|b| ≤ 2 and random `out_ready` → counts match a reference model and x,y ordering is preserved.

Source files
------------

// File: rtl/mandelbrot_pkg.sv
// Shared fixed-point types, escape constant and FSM state encoding for the
// Mandelbrot iterator and its neighbours in the write path.
package mandelbrot_pkg;

  localparam int DATA_W = 32;
  localparam int FRAC_W = 28;
  localparam int PROD_W = 2 * DATA_W;

  // 4.0 in Q8.56, widened by one bit so |z|^2 can be compared untruncated
  localparam logic signed [PROD_W:0] ESCAPE_R2 = 65'sh0_0400_0000_0000_0000;

  typedef logic signed [DATA_W-1:0] fxp_t;
  typedef logic signed [PROD_W-1:0] prod_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } iter_state_t;

endpackage

// File: rtl/mandelbrot_iterator_fxp_mul.sv
// Combinational signed Q4.28 x Q4.28 -> Q8.56 multiplier, full precision.
module fxp_mul
  import mandelbrot_pkg::*;
(
  input  fxp_t  op_a,
  input  fxp_t  op_b,
  output prod_t prod
);

  prod_t ext_a;
  prod_t ext_b;

  assign ext_a = {{DATA_W{op_a[DATA_W-1]}}, op_a};
  assign ext_b = {{DATA_W{op_b[DATA_W-1]}}, op_b};
  assign prod  = ext_a * ext_b;

endmodule

// File: rtl/mandelbrot_iterator.sv
// Escape-time engine: iterates z <- z^2 + c per pixel and returns the count.
// Optional periodicity early-exit is compiled in with MANDEL_PERIOD_CHECK_EN.
module mandelbrot_iterator
  import mandelbrot_pkg::*;
#(
  parameter int ITER_W   = 8,
  parameter int MAX_ITER = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [9:0]        x_in,
  input  logic [9:0]        y_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ITER_W-1:0] count_out,
  output logic [9:0]        x_out,
  output logic [9:0]        y_out
);

  localparam logic [ITER_W-1:0] MAX_K = ITER_W'(MAX_ITER);

  iter_state_t state, state_nxt;

  fxp_t a_r, b_r, zr, zi, zr_nxt, zi_nxt;
  logic [9:0] x_r, y_r;
  logic [ITER_W-1:0] k, count_nxt;
  prod_t p_rr, p_ii, p_ri;
  logic signed [PROD_W:0] mag2;
  logic escaped, accept, finish;

  fxp_mul u_mul_rr (.op_a(zr), .op_b(zr), .prod(p_rr));
  fxp_mul u_mul_ii (.op_a(zi), .op_b(zi), .prod(p_ii));
  fxp_mul u_mul_ri (.op_a(zr), .op_b(zi), .prod(p_ri));

  assign mag2    = {p_rr[PROD_W-1], p_rr} + {p_ii[PROD_W-1], p_ii};
  assign escaped = mag2 > ESCAPE_R2;

  // Shifting 2*zr*zi right by FRAC_W is the same as shifting zr*zi by FRAC_W-1
  assign zr_nxt = fxp_t'((p_rr - p_ii) >>> FRAC_W) + a_r;
  assign zi_nxt = fxp_t'(p_ri >>> (FRAC_W - 1)) + b_r;

`ifdef MANDEL_PERIOD_CHECK_EN
  fxp_t zs_r, zs_i;
  logic k_pow2, period_hit;

  assign k_pow2     = (k != '0) && ((k & (k - ITER_W'(1))) == '0);
  assign period_hit = (k > ITER_W'(1)) && !k_pow2 && (zr == zs_r) && (zi == zs_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      zs_r <= '0;
      zs_i <= '0;
    end else if (state == ITER && k_pow2) begin
      zs_r <= zr;
      zs_i <= zi;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    count_nxt = k;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = ITER;
        end
      end
      ITER: begin
        if (escaped) begin
          finish = 1'b1;
        end else if (k == MAX_K) begin
          finish = 1'b1;
`ifdef MANDEL_PERIOD_CHECK_EN
        end else if (period_hit) begin
          finish    = 1'b1;
          count_nxt = MAX_K;
`endif
        end
        if (finish) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_r       <= '0;
      b_r       <= '0;
      x_r       <= '0;
      y_r       <= '0;
      zr        <= '0;
      zi        <= '0;
      k         <= '0;
      count_out <= '0;
      x_out     <= '0;
      y_out     <= '0;
    end else begin
      if (accept) begin
        a_r <= a;
        b_r <= b;
        x_r <= x_in;
        y_r <= y_in;
        zr  <= '0;
        zi  <= '0;
        k   <= '0;
      end else if (state == ITER && !finish) begin
        zr <= zr_nxt;
        zi <= zi_nxt;
        k  <= k + ITER_W'(1);
      end
      if (finish) begin
        count_out <= count_nxt;
        x_out     <= x_r;
        y_out     <= y_r;
      end
    end
  end

endmodule

// File: tb/tb_mandelbrot_iterator.sv
// Self-checking bench for mandelbrot_iterator: directed pixels with literal
// expectations plus a per-cycle monitor against a plain-arithmetic model.
module tb_mandelbrot_iterator;

  localparam int MAX_ITER = 255;
  localparam logic [31:0] ONE  = 32'h1000_0000;
  localparam logic [31:0] TWO  = 32'h2000_0000;
  localparam logic [31:0] MTWO = 32'hE000_0000;
  localparam logic [31:0] HALF = 32'h0800_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [9:0]  x_in;
  logic [9:0]  y_in;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  count_out;
  logic [9:0]  x_out;
  logic [9:0]  y_out;

  int checks = 0;
  int errors = 0;
  int n_done = 0;
  longint cyc = 0;

  typedef struct {
    int         cnt;
    logic [9:0] x;
    logic [9:0] y;
    longint     acc;
  } exp_t;

  exp_t exp_q[$];
  bit   prev_valid = 1'b0;

  mandelbrot_iterator #(.ITER_W(8), .MAX_ITER(MAX_ITER)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .x_in(x_in), .y_in(y_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .count_out(count_out), .x_out(x_out), .y_out(y_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Escape-time count straight from the iteration rule, in 64-bit integers
  function automatic int model_count(input logic [31:0] av, input logic [31:0] bv);
    longint ca, cb, zr, zi, rr, ii, ri;
    ca = longint'($signed(av));
    cb = longint'($signed(bv));
    zr = 0;
    zi = 0;
    for (int k = 0; k <= MAX_ITER; k++) begin
      rr = zr * zr;
      ii = zi * zi;
      ri = zr * zi;
      if (rr + ii > (longint'(4) <<< 56)) return k;
      if (k == MAX_ITER) return MAX_ITER;
      zr = longint'(int'(((rr - ii) >>> 28) + ca));
      zi = longint'(int'(((2 * ri) >>> 28) + cb));
    end
    return MAX_ITER;
  endfunction

  function automatic logic [31:0] rand_coord();
    logic [31:0] r;
    r = 32'($urandom_range(32'h4000_0000, 0));
    return r - TWO;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      prev_valid = 1'b0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got out_valid=1 expected no pending pixel at cycle %0d", cyc);
        end else begin
          check("mon_count", count_out, exp_q[0].cnt);
          check("mon_x", x_out, exp_q[0].x);
          check("mon_y", y_out, exp_q[0].y);
          check("mon_in_ready_busy", in_ready, 0);
          if (!prev_valid) begin
`ifdef MANDEL_PERIOD_CHECK_EN
            if (exp_q[0].cnt == MAX_ITER)
              check("mon_latency_le", (cyc - exp_q[0].acc) <= MAX_ITER + 1, 1);
            else
              check("mon_latency", cyc - exp_q[0].acc, exp_q[0].cnt + 1);
`else
            check("mon_latency", cyc - exp_q[0].acc, exp_q[0].cnt + 1);
`endif
          end
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_done++;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e.cnt = model_count(a, b);
        e.x   = x_in;
        e.y   = y_in;
        e.acc = cyc + 1;
        exp_q.push_back(e);
      end
      prev_valid = out_valid;
    end
  end

  // Called at #1 after a posedge; returns at #1 after the accept edge
  task automatic accept_pixel(input logic [31:0] av, input logic [31:0] bv,
                              input logic [9:0] xv, input logic [9:0] yv);
    bit acc;
    int guard;
    acc = 1'b0;
    guard = 0;
    a = av; b = bv; x_in = xv; y_in = yv;
    in_valid = 1'b1;
    while (!acc && guard < 3000) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  task automatic run_pixel(input logic [31:0] av, input logic [31:0] bv,
                           input logic [9:0] xv, input logic [9:0] yv,
                           input int exp_cnt, input int hold);
    int lat;
    lat = 0;
    accept_pixel(av, bv, xv, yv);
    while (!out_valid && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) begin
      check("result_timeout", 0, 1);
      return;
    end
    check("dir_count", count_out, exp_cnt);
    check("dir_xy", {y_out, x_out}, {yv, xv});
`ifdef MANDEL_PERIOD_CHECK_EN
    if (exp_cnt == MAX_ITER) check("dir_latency_short", lat < 10, 1);
    else                     check("dir_latency", lat, exp_cnt + 1);
`else
    check("dir_latency", lat, exp_cnt + 1);
`endif
    if (hold > 0) begin
      a = 32'h0; b = 32'h0; x_in = 10'd999; y_in = 10'd999;
      in_valid = 1'b1;
      repeat (hold) begin
        @(posedge clk);
        #1;
      end
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_count", count_out, exp_cnt);
      check("hold_xy", {y_out, x_out}, {yv, xv});
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("post_hs_valid", out_valid, 0);
    check("post_hs_ready", in_ready, 1);
  endtask

  initial begin
    int model_pins[5];
    int guard;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; x_in = '0; y_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_count", count_out, 0);
    check("rst_xy", {y_out, x_out}, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    model_pins[0] = model_count(32'h0, 32'h0);
    model_pins[1] = model_count(ONE, 32'h0);
    model_pins[2] = model_count(TWO, 32'h0);
    model_pins[3] = model_count(MTWO, 32'h0);
    model_pins[4] = model_count(HALF, 32'h0);
    check("model_c0", model_pins[0], 255);
    check("model_c1", model_pins[1], 3);
    check("model_c2", model_pins[2], 2);
    check("model_cm2", model_pins[3], 255);
    check("model_chalf", model_pins[4], 5);

    @(posedge clk);
    #1;
    run_pixel(32'h0, 32'h0, 10'd10,  10'd20,  255, 0);
    run_pixel(ONE,   32'h0, 10'd1,   10'd2,   3,   0);
    run_pixel(TWO,   32'h0, 10'd3,   10'd4,   2,   0);
    run_pixel(MTWO,  32'h0, 10'd5,   10'd6,   255, 0);
    run_pixel(HALF,  32'h0, 10'd7,   10'd8,   5,   0);
    run_pixel(32'h0, ONE,   10'd9,   10'd11,  255, 0);
    run_pixel(32'hF000_0000, 32'h0, 10'd12, 10'd13, 255, 0);
    run_pixel(ONE,   32'h0, 10'd1023, 10'd1022, 3, 20);

    // Reset in the middle of a long c = 0 run
    accept_pixel(32'h0, 32'h0, 10'd50, 10'd60);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_count", count_out, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_pixel(ONE, 32'h0, 10'd77, 10'd88, 3, 0);

    // Back-to-back random stream with random backpressure
    n_done = 0;
    fork
      begin
        for (int i = 0; i < 16; i++)
          accept_pixel(rand_coord(), rand_coord(), 10'(100 + i), 10'(3 * i));
      end
      begin
        guard = 0;
        while (n_done < 16 && guard < 20000) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
          guard++;
        end
        out_ready = 1'b0;
      end
    join
    check("stream_done", n_done, 16);
    check("stream_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
